multicycle_control_unit: RTL
============================

# multicycle_control_unit

Finite-state control for the multi-cycle RV32I(+M) core: it sequences fetch, decode, execute, memory and writeback over several cycles, sharing one ALU and one memory port. It drives the same datapath selects as the single-cycle decoder (immSrc, aluControl, loadSrc, storeSrc). It adds a memory ready handshake with a bounded-wait fault, a start/done handshake to an iterative mul/div unit, and an illegal-instruction trap state.

## Interface
- MEM_WAIT_MAX, 15: cycles memReq may remain unanswered before busFault; counter width is $clog2(MEM_WAIT_MAX+1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- op  in  7  opcode, from instruction register
- funct3  in  3  from instruction register
- funct7  in  7  from instruction register
- beq, bne, blt, bge, bltu, bgeu  in  1 each  comparator flags for current operands
- memReady  in  1  memory accepted/completed current request
- mdDone  in  1  mul/div result valid
- memReq  out  1  memory access request
- adrSrc  out  1  0 = PC, 1 = ALU result as address
- memWrite, irWrite, pcWrite, regWrite  out  1 each  enables
- aluSrcA  out  2  0 PC, 1 oldPC, 2 rs1
- aluSrcB  out  2  0 rs2, 1 imm, 2 const 4
- resultSrc  out  2  0 ALU, 1 load data, 2 PC+4, 3 mul/div result
- immSrc  out  3  I/S/B/U/J select
- aluControl  out  5  ALU operation
- loadSrc  out  3  lb/lh/lw/lbu/lhu = 0/1/2/3/4; default 2
- storeSrc  out  2  sb/sh/sw = 0/1/2; default 2
- mdStart  out  1  one-cycle start pulse to mul/div
- illegal, busFault  out  1 each  sticky trap causes
- state  out  4  current state, debug only

## Operation
- States: FETCH, DECODE, EXECR, EXECI, MEMADR, MEMRD, MEMWR, MULDIV, ALUWB, MEMWB, BRANCH, JAL, JALR, UPPER, TRAP.
- FETCH: memReq=1, adrSrc=0, aluSrcA=0, aluSrcB=2. On memReady: irWrite=1, pcWrite=1 (PC+4), go to DECODE.
- DECODE: aluSrcA=1, aluSrcB=1 (oldPC+imm for the branch target). Dispatch on op:
  - 0110011 → EXECR, or MULDIV when funct7=0x01
  - 0010011 → EXECI
  - 0000011 and 0100011 → MEMADR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - 1100111 → JALR
  - 0110111 and 0010111 → UPPER
  - anything else → TRAP with illegal=1
- EXECR/EXECI/UPPER: compute, then ALUWB (regWrite=1, resultSrc=0). ALUWB returns to FETCH.
- MEMADR computes rs1+imm, then:
  - load → MEMRD: memReq=1, adrSrc=1; on memReady go to MEMWB (regWrite=1, resultSrc=1).
  - store → MEMWR: memReq=1, memWrite=1, adrSrc=1; on memReady go to FETCH.
- BRANCH: pcWrite is asserted per funct3 using beq/bne/blt/bge/bltu/bgeu. funct3 2 or 3 → TRAP, illegal=1. Otherwise → FETCH.
- JAL/JALR: pcWrite=1 to the target, regWrite=1, resultSrc=2, then FETCH.
- MULDIV: mdStart=1 on the entry cycle only. Hold until mdDone, then ALUWB with resultSrc=3.
- Illegal funct3 for a load (3, 6, 7) or a store (≥3) → TRAP, illegal=1. loadSrc/storeSrc are driven only for op 0000011/0100011; otherwise they take their defaults.
- Wait counter:
  - Clears on entering any memReq state.
  - Increments each cycle memReq=1 and memReady=0.
  - On reaching MEM_WAIT_MAX without memReady → TRAP, busFault=1.
  - memReady in that same cycle wins: no fault.
- TRAP: every enable is 0, memReq=0. TRAP is absorbing until reset.

## Timing
- Outputs are Moore: decoded from the registered state plus the stable IR fields. memReady and mdDone affect only the next state, plus irWrite/pcWrite in FETCH.
- Minimum cycles with memReady=1 immediately:
  - R/I/U: 4
  - load: 5
  - store: 4
  - branch: 3
  - jal/jalr: 3
  - mul/div: 4 + mdDone wait
- Reset values (state forced to FETCH): every enable 0, memReq=0, mdStart=0, illegal=0, busFault=0, counter=0, loadSrc=2, storeSrc=2. FETCH outputs appear from the first cycle after reset falls.
- Reset mid-instruction aborts it. No partial writes are issued after the reset cycle, and a pending mdStart is not reissued.

## Configuration
- RV_M_EXT_EN defined: MULDIV state, mdStart and resultSrc=3 are present.
- RV_M_EXT_EN undefined: R-type with funct7=0x01 goes to TRAP with illegal=1; mdStart is tied to 0 and mdDone is ignored.

## Test plan
- add x3,x1,x2 (0x002081B3) with memReady held 1 → states FETCH, DECODE, EXECR, ALUWB; regWrite=1 only in cycle 4.
- lw with memReady delayed 3 cycles in MEMRD → MEMRD held 4 cycles; MEMWB with loadSrc=2; no busFault.
- memReady held 0 in FETCH, MEM_WAIT_MAX=15 → TRAP after 15 cycles with busFault=1. Repeat with memReady arriving on cycle 15 → DECODE, no fault.
- beq with beq flag=0, then bne with bne flag=1 → pcWrite=0 in BRANCH, then pcWrite=1 in BRANCH.
- mul (funct7=0x01), mdDone after 8 cycles → single mdStart pulse, then ALUWB with resultSrc=3. Without RV_M_EXT_EN → TRAP, illegal=1.
- reset asserted during MEMWR → next state FETCH, all outputs at reset values, illegal/busFault cleared.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I(+M) control FSM with memory wait fault and trap
// Optional mul/div sequencing is enabled by defining RV_M_EXT_EN.
module multicycle_control_unit #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       beq,
  input  logic       bne,
  input  logic       blt,
  input  logic       bge,
  input  logic       bltu,
  input  logic       bgeu,
  input  logic       memReady,
  input  logic       mdDone,
  output logic       memReq,
  output logic       adrSrc,
  output logic       memWrite,
  output logic       irWrite,
  output logic       pcWrite,
  output logic       regWrite,
  output logic [1:0] aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] resultSrc,
  output logic [2:0] immSrc,
  output logic [4:0] aluControl,
  output logic [2:0] loadSrc,
  output logic [1:0] storeSrc,
  output logic       mdStart,
  output logic       illegal,
  output logic       busFault,
  output logic [3:0] state
);
  localparam int CW = $clog2(MEM_WAIT_MAX + 1);

  localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_L = 7'b0000011,
                         OP_S = 7'b0100011, OP_B = 7'b1100011, OP_JAL = 7'b1101111,
                         OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

  localparam logic [4:0] ALU_ADD = 5'd0, ALU_SUB = 5'd1, ALU_SLL = 5'd2, ALU_SLT = 5'd3,
                         ALU_SLTU = 5'd4, ALU_XOR = 5'd5, ALU_SRL = 5'd6, ALU_SRA = 5'd7,
                         ALU_OR = 5'd8, ALU_AND = 5'd9, ALU_PASSB = 5'd10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXECR, S_EXECI, S_MEMADR, S_MEMRD, S_MEMWR, S_MULDIV,
    S_ALUWB, S_MEMWB, S_BRANCH, S_JAL, S_JALR, S_UPPER, S_TRAP
  } state_t;

  state_t        r_state, w_next;
  logic [CW-1:0] r_wait;
  logic          r_illegal, r_bus;
  logic          w_set_ill, w_set_bus, w_mem_req, w_wait_exp, w_taken, w_md_op;

  function automatic logic [4:0] alu_op(input logic [2:0] f3, input logic alt);
    case (f3)
      3'd0:    alu_op = alt ? ALU_SUB : ALU_ADD;
      3'd1:    alu_op = ALU_SLL;
      3'd2:    alu_op = ALU_SLT;
      3'd3:    alu_op = ALU_SLTU;
      3'd4:    alu_op = ALU_XOR;
      3'd5:    alu_op = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_op = ALU_OR;
      default: alu_op = ALU_AND;
    endcase
  endfunction

  assign w_mem_req  = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
  assign w_wait_exp = w_mem_req && !memReady && (r_wait == CW'(MEM_WAIT_MAX - 1));
  assign w_md_op    = (op == OP_R) && (funct7 == 7'h01);

  always_comb begin
    case (funct3)
      3'd0:    w_taken = beq;
      3'd1:    w_taken = bne;
      3'd4:    w_taken = blt;
      3'd5:    w_taken = bge;
      3'd6:    w_taken = bltu;
      3'd7:    w_taken = bgeu;
      default: w_taken = 1'b0;
    endcase
  end

`ifdef RV_M_EXT_EN
  logic r_md_busy;
  always_ff @(posedge clk) begin
    if (reset) r_md_busy <= 1'b0;
    else       r_md_busy <= (r_state == S_MULDIV);
  end
`else
  logic w_unused_md;
  assign w_unused_md = mdDone;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_FETCH;
      r_wait    <= '0;
      r_illegal <= 1'b0;
      r_bus     <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_set_ill) r_illegal <= 1'b1;
      if (w_set_bus) r_bus <= 1'b1;
      // any state change restarts the wait window for the next request
      if (w_next != r_state)             r_wait <= '0;
      else if (w_mem_req && !memReady)   r_wait <= r_wait + 1'b1;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_set_ill = 1'b0;
    w_set_bus = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (memReady) w_next = S_DECODE;
        else if (w_wait_exp) begin w_next = S_TRAP; w_set_bus = 1'b1; end
      end
      S_DECODE: begin
        case (op)
          OP_R: begin
            if (w_md_op) begin
`ifdef RV_M_EXT_EN
              w_next = S_MULDIV;
`else
              w_next = S_TRAP; w_set_ill = 1'b1;
`endif
            end else w_next = S_EXECR;
          end
          OP_I: w_next = S_EXECI;
          OP_L: begin
            if (funct3 == 3'd3 || funct3 >= 3'd6) begin w_next = S_TRAP; w_set_ill = 1'b1; end
            else w_next = S_MEMADR;
          end
          OP_S: begin
            if (funct3 >= 3'd3) begin w_next = S_TRAP; w_set_ill = 1'b1; end
            else w_next = S_MEMADR;
          end
          OP_B:            w_next = S_BRANCH;
          OP_JAL:          w_next = S_JAL;
          OP_JALR:         w_next = S_JALR;
          OP_LUI, OP_AUIPC: w_next = S_UPPER;
          default: begin w_next = S_TRAP; w_set_ill = 1'b1; end
        endcase
      end
      S_EXECR, S_EXECI, S_UPPER: w_next = S_ALUWB;
      S_MEMADR: w_next = (op == OP_L) ? S_MEMRD : S_MEMWR;
      S_MEMRD: begin
        if (memReady) w_next = S_MEMWB;
        else if (w_wait_exp) begin w_next = S_TRAP; w_set_bus = 1'b1; end
      end
      S_MEMWR: begin
        if (memReady) w_next = S_FETCH;
        else if (w_wait_exp) begin w_next = S_TRAP; w_set_bus = 1'b1; end
      end
      S_MULDIV: begin
`ifdef RV_M_EXT_EN
        if (mdDone) w_next = S_ALUWB;
`else
        w_next = S_TRAP; w_set_ill = 1'b1;
`endif
      end
      S_ALUWB, S_MEMWB, S_JAL, S_JALR: w_next = S_FETCH;
      S_BRANCH: begin
        if (funct3 == 3'd2 || funct3 == 3'd3) begin w_next = S_TRAP; w_set_ill = 1'b1; end
        else w_next = S_FETCH;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  always_comb begin
    memReq = 1'b0; adrSrc = 1'b0; memWrite = 1'b0; irWrite = 1'b0;
    pcWrite = 1'b0; regWrite = 1'b0; mdStart = 1'b0;
    aluSrcA = 2'd0; aluSrcB = 2'd0; resultSrc = 2'd0; immSrc = 3'd0;
    aluControl = ALU_ADD; loadSrc = 3'd2; storeSrc = 2'd2;
    // reset masks every output so an aborted instruction issues nothing in the reset cycle
    if (!reset) begin
      case (op)
        OP_S:             immSrc = 3'd1;
        OP_B:             immSrc = 3'd2;
        OP_LUI, OP_AUIPC: immSrc = 3'd3;
        OP_JAL:           immSrc = 3'd4;
        default:          immSrc = 3'd0;
      endcase
      if (r_state != S_FETCH && r_state != S_TRAP) begin
        if (op == OP_L) begin
          case (funct3)
            3'd0: loadSrc = 3'd0;
            3'd1: loadSrc = 3'd1;
            3'd4: loadSrc = 3'd3;
            3'd5: loadSrc = 3'd4;
            default: loadSrc = 3'd2;
          endcase
        end
        if (op == OP_S && funct3 < 3'd3) storeSrc = funct3[1:0];
      end
      case (r_state)
        S_FETCH: begin
          memReq = 1'b1; aluSrcB = 2'd2;
          irWrite = memReady; pcWrite = memReady;
        end
        S_DECODE: begin aluSrcA = 2'd1; aluSrcB = 2'd1; end
        S_EXECR:  begin aluSrcA = 2'd2; aluControl = alu_op(funct3, funct7[5]); end
        S_EXECI: begin
          aluSrcA = 2'd2; aluSrcB = 2'd1;
          aluControl = alu_op(funct3, (funct3 == 3'd5) && funct7[5]);
        end
        S_UPPER: begin
          aluSrcB = 2'd1;
          if (op == OP_LUI) aluControl = ALU_PASSB;
          else aluSrcA = 2'd1;
        end
        S_MEMADR: begin aluSrcA = 2'd2; aluSrcB = 2'd1; end
        S_MEMRD:  begin memReq = 1'b1; adrSrc = 1'b1; end
        S_MEMWR:  begin memReq = 1'b1; adrSrc = 1'b1; memWrite = 1'b1; end
        S_MULDIV: begin
          aluSrcA = 2'd2;
`ifdef RV_M_EXT_EN
          mdStart = !r_md_busy;
`endif
        end
        S_ALUWB: begin
          regWrite = 1'b1;
`ifdef RV_M_EXT_EN
          if (w_md_op) resultSrc = 2'd3;
`endif
        end
        S_MEMWB:  begin regWrite = 1'b1; resultSrc = 2'd1; end
        S_BRANCH: begin aluSrcA = 2'd2; aluControl = ALU_SUB; pcWrite = w_taken; end
        S_JAL:    begin aluSrcA = 2'd1; aluSrcB = 2'd1; pcWrite = 1'b1; regWrite = 1'b1; resultSrc = 2'd2; end
        S_JALR:   begin aluSrcA = 2'd2; aluSrcB = 2'd1; pcWrite = 1'b1; regWrite = 1'b1; resultSrc = 2'd2; end
        default:  ;
      endcase
    end
  end

  assign illegal  = r_illegal && !reset;
  assign busFault = r_bus && !reset;
  assign state    = r_state;
endmodule
